// File: rtl/id_pkg.sv
// Shared decode constants, instruction classes, operation codes and immediate helpers for id_stage_pipe.
// Multiply/divide codes are emitted only when ID_MULDIV_DECODE_EN is defined.
package id_pkg;

   localparam logic [4:0] OPC5_LOAD      = 5'b00000;
   localparam logic [4:0] OPC5_OP_IMM    = 5'b00100;
   localparam logic [4:0] OPC5_AUIPC     = 5'b00101;
   localparam logic [4:0] OPC5_OP_IMM_32 = 5'b00110;
   localparam logic [4:0] OPC5_STORE     = 5'b01000;
   localparam logic [4:0] OPC5_OP        = 5'b01100;
   localparam logic [4:0] OPC5_LUI       = 5'b01101;
   localparam logic [4:0] OPC5_OP_32     = 5'b01110;
   localparam logic [4:0] OPC5_BRANCH    = 5'b11000;
   localparam logic [4:0] OPC5_JALR      = 5'b11001;
   localparam logic [4:0] OPC5_JAL       = 5'b11011;
   localparam logic [4:0] OPC5_SYSTEM    = 5'b11100;

   // Bit positions inside the one-hot ex_inst_type {sys,rrw,riw,ri,rr,br,ld,st}
   localparam int T_ST = 0, T_LD = 1, T_BR = 2, T_RR = 3, T_RI = 4, T_RIW = 5, T_RRW = 6, T_SYS = 7;

   localparam logic [7:0] OPC_NOP = 8'd0,  OPC_ADD = 8'd1,  OPC_SUB = 8'd2,  OPC_SLL = 8'd3;
   localparam logic [7:0] OPC_SLT = 8'd4,  OPC_SLTU = 8'd5, OPC_XOR = 8'd6,  OPC_SRL = 8'd7;
   localparam logic [7:0] OPC_SRA = 8'd8,  OPC_OR = 8'd9,   OPC_AND = 8'd10, OPC_LUI = 8'd11;
   localparam logic [7:0] OPC_AUIPC = 8'd12, OPC_JAL = 8'd13, OPC_JALR = 8'd14;
   localparam logic [7:0] OPC_BEQ = 8'd15, OPC_BNE = 8'd16, OPC_BLT = 8'd17, OPC_BGE = 8'd18;
   localparam logic [7:0] OPC_BLTU = 8'd19, OPC_BGEU = 8'd20, OPC_LOAD = 8'd21, OPC_STORE = 8'd22;
   localparam logic [7:0] OPC_ECALL = 8'd23, OPC_MRET = 8'd24;
   localparam logic [7:0] OPC_CSRRW = 8'd25, OPC_CSRRS = 8'd26, OPC_CSRRC = 8'd27;
   localparam logic [7:0] OPC_CSRRWI = 8'd28, OPC_CSRRSI = 8'd29, OPC_CSRRCI = 8'd30;
   localparam logic [7:0] OPC_MUL = 8'd32, OPC_MULH = 8'd33, OPC_MULHSU = 8'd34, OPC_MULHU = 8'd35;
   localparam logic [7:0] OPC_DIV = 8'd36, OPC_DIVU = 8'd37, OPC_REM = 8'd38, OPC_REMU = 8'd39;
   localparam logic [7:0] OPC_MULW = 8'd40, OPC_DIVW = 8'd41, OPC_DIVUW = 8'd42;
   localparam logic [7:0] OPC_REMW = 8'd43, OPC_REMUW = 8'd44;

   typedef enum logic [1:0] {OP1_RS = 2'd0, OP1_PC = 2'd1, OP1_UIMM = 2'd2} op1_sel_e;
   typedef enum logic [1:0] {OP2_RS = 2'd0, OP2_IMM_I = 2'd1, OP2_IMM_U = 2'd2, OP2_PC = 2'd3} op2_sel_e;

   // Results are 64 bits wide; callers size-cast down to their own XLEN.
   function automatic logic [63:0] sext12(input logic [11:0] v);
      return {{52{v[11]}}, v};
   endfunction

   function automatic logic [63:0] sext32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

   function automatic logic [7:0] alu_opc(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  return alt ? OPC_SUB : OPC_ADD;
         3'b001:  return OPC_SLL;
         3'b010:  return OPC_SLT;
         3'b011:  return OPC_SLTU;
         3'b100:  return OPC_XOR;
         3'b101:  return alt ? OPC_SRA : OPC_SRL;
         3'b110:  return OPC_OR;
         3'b111:  return OPC_AND;
         default: return OPC_NOP;
      endcase
   endfunction

   function automatic logic [7:0] br_opc(input logic [2:0] f3);
      case (f3)
         3'b000:  return OPC_BEQ;
         3'b001:  return OPC_BNE;
         3'b100:  return OPC_BLT;
         3'b101:  return OPC_BGE;
         3'b110:  return OPC_BLTU;
         3'b111:  return OPC_BGEU;
         default: return OPC_NOP;
      endcase
   endfunction

   // OPC_NOP marks a funct3 with no defined M-extension operation.
   function automatic logic [7:0] md_opc(input logic [2:0] f3, input logic w);
      case ({w, f3})
         4'b0000: return OPC_MUL;
         4'b0001: return OPC_MULH;
         4'b0010: return OPC_MULHSU;
         4'b0011: return OPC_MULHU;
         4'b0100: return OPC_DIV;
         4'b0101: return OPC_DIVU;
         4'b0110: return OPC_REM;
         4'b0111: return OPC_REMU;
         4'b1000: return OPC_MULW;
         4'b1100: return OPC_DIVW;
         4'b1101: return OPC_DIVUW;
         4'b1110: return OPC_REMW;
         4'b1111: return OPC_REMUW;
         default: return OPC_NOP;
      endcase
   endfunction

endpackage

// File: rtl/id_stage_pipe_fwd.sv
// Priority bypass select for one source operand; index 0 is the youngest producer.
module id_fwd_mux #(
   parameter int NUM_FWD = 3,
   parameter int XLEN    = 64
) (
   input  logic [4:0]              rs_addr_i,
   input  logic [XLEN-1:0]         rf_data_i,
   input  logic [NUM_FWD-1:0]      fwd_ena_i,
   input  logic [5*NUM_FWD-1:0]    fwd_addr_i,
   input  logic [XLEN*NUM_FWD-1:0] fwd_data_i,
   output logic [XLEN-1:0]         rs_data_o
);
   logic [XLEN-1:0] sel_s;

   // Walk oldest to youngest so the lowest-index match is the one that survives
   always_comb begin
      sel_s = rf_data_i;
      for (int i = NUM_FWD - 1; i >= 0; i--) begin
         if (fwd_ena_i[i] && (fwd_addr_i[5*i +: 5] == rs_addr_i)) begin
            sel_s = fwd_data_i[XLEN*i +: XLEN];
         end else begin
            sel_s = sel_s;
         end
      end
   end

   assign rs_data_o = (rs_addr_i == 5'd0) ? {XLEN{1'b0}} : sel_s;

endmodule

// File: rtl/id_stage_pipe.sv
// RV64I/Zicsr decode stage with bypass, load-use stall, output register and jalr redirect.
// Define ID_MULDIV_DECODE_EN to decode the M extension; otherwise those encodings are NOPs.
module id_stage_pipe
   import id_pkg::*;
#(
   parameter int XLEN    = 64,
   parameter int PC_W    = 64,
   parameter int NUM_FWD = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    if_valid,
   output logic                    if_ready,
   input  logic [31:0]             if_inst,
   input  logic [PC_W-1:0]         if_pc,
   output logic [4:0]              rf_rs1_addr,
   output logic [4:0]              rf_rs2_addr,
   input  logic [XLEN-1:0]         rf_rs1_data,
   input  logic [XLEN-1:0]         rf_rs2_data,
   input  logic [NUM_FWD-1:0]      fwd_ena,
   input  logic [5*NUM_FWD-1:0]    fwd_addr,
   input  logic [XLEN*NUM_FWD-1:0] fwd_data,
   input  logic                    exe_load_vld,
   input  logic [4:0]              exe_load_rd,
   input  logic                    flush_i,
   output logic                    ex_valid,
   input  logic                    ex_ready,
   output logic [7:0]              ex_inst_type,
   output logic [7:0]              ex_inst_opcode,
   output logic [XLEN-1:0]         ex_op1,
   output logic [XLEN-1:0]         ex_op2,
   output logic                    ex_rd_w_ena,
   output logic [4:0]              ex_rd_w_addr,
   output logic [PC_W-1:0]         ex_pc,
   output logic [11:0]             ex_mem_offset,
   output logic [2:0]              ex_mem_op,
   output logic                    redirect_vld,
   output logic [PC_W-1:0]         redirect_pc,
   output logic [15:0]             stall_cnt
);
   logic [4:0] opc5_s, rd_s;
   logic [2:0] f3_s;
   logic [6:0] f7_s;
   logic       ok_s, use1_s, use2_s, wr_s, jalr_s;
   logic [7:0] ty_s, code_s;
   logic [11:0] moff_s;
   op1_sel_e   op1_sel_s;
   op2_sel_e   op2_sel_s;

   assign opc5_s = if_inst[6:2];
   assign rd_s   = if_inst[11:7];
   assign f3_s   = if_inst[14:12];
   assign f7_s   = if_inst[31:25];

   // Instruction decode: class, operation, register usage and operand sources
   always_comb begin
      ok_s = 1'b0; ty_s = 8'h00; code_s = OPC_NOP; moff_s = 12'h000;
      use1_s = 1'b0; use2_s = 1'b0; wr_s = 1'b0; jalr_s = 1'b0;
      op1_sel_s = OP1_RS; op2_sel_s = OP2_RS;
      if (if_inst[1:0] == 2'b11) begin
         case (opc5_s)
            OPC5_OP_IMM: begin
               ty_s[T_RI] = 1'b1; use1_s = 1'b1; wr_s = 1'b1; op2_sel_s = OP2_IMM_I;
               code_s = alu_opc(f3_s, (f3_s == 3'b101) & if_inst[30]);
               case (f3_s)
                  3'b001:  ok_s = (if_inst[31:26] == 6'b000000);
                  3'b101:  ok_s = (if_inst[31:26] == 6'b000000) | (if_inst[31:26] == 6'b010000);
                  default: ok_s = 1'b1;
               endcase
            end
            OPC5_OP_IMM_32: begin
               ty_s[T_RIW] = 1'b1; use1_s = 1'b1; wr_s = 1'b1; op2_sel_s = OP2_IMM_I;
               code_s = alu_opc(f3_s, (f3_s == 3'b101) & if_inst[30]);
               case (f3_s)
                  3'b000:  ok_s = 1'b1;
                  3'b001:  ok_s = (f7_s == 7'b0000000);
                  3'b101:  ok_s = (f7_s == 7'b0000000) | (f7_s == 7'b0100000);
                  default: ok_s = 1'b0;
               endcase
            end
            OPC5_OP, OPC5_OP_32: begin
               if (opc5_s == OPC5_OP) begin
                  ty_s[T_RR] = 1'b1;
               end else begin
                  ty_s[T_RRW] = 1'b1;
               end
               use1_s = 1'b1; use2_s = 1'b1; wr_s = 1'b1;
               if (f7_s == 7'b0000000) begin
                  code_s = alu_opc(f3_s, 1'b0);
                  ok_s = (opc5_s == OPC5_OP) | (f3_s == 3'b000) | (f3_s == 3'b001) | (f3_s == 3'b101);
               end else if (f7_s == 7'b0100000) begin
                  code_s = alu_opc(f3_s, 1'b1);
                  ok_s = (f3_s == 3'b000) | (f3_s == 3'b101);
`ifdef ID_MULDIV_DECODE_EN
               end else if (f7_s == 7'b0000001) begin
                  code_s = md_opc(f3_s, opc5_s == OPC5_OP_32);
                  ok_s = (code_s != OPC_NOP);
`endif
               end else begin
                  ok_s = 1'b0;
               end
            end
            OPC5_LOAD: begin
               ty_s[T_LD] = 1'b1; code_s = OPC_LOAD; use1_s = 1'b1; wr_s = 1'b1;
               op2_sel_s = OP2_IMM_I; moff_s = if_inst[31:20]; ok_s = (f3_s != 3'b111);
            end
            OPC5_STORE: begin
               ty_s[T_ST] = 1'b1; code_s = OPC_STORE; use1_s = 1'b1; use2_s = 1'b1;
               moff_s = {if_inst[31:25], if_inst[11:7]}; ok_s = ~f3_s[2];
            end
            OPC5_BRANCH: begin
               ty_s[T_BR] = 1'b1; code_s = br_opc(f3_s); use1_s = 1'b1; use2_s = 1'b1;
               ok_s = (code_s != OPC_NOP);
            end
            OPC5_JAL: begin
               ty_s[T_BR] = 1'b1; code_s = OPC_JAL; wr_s = 1'b1; ok_s = 1'b1;
               op1_sel_s = OP1_PC; op2_sel_s = OP2_PC;
            end
            OPC5_JALR: begin
               ty_s[T_BR] = 1'b1; code_s = OPC_JALR; use1_s = 1'b1; wr_s = 1'b1;
               op2_sel_s = OP2_PC; jalr_s = 1'b1; ok_s = (f3_s == 3'b000);
            end
            OPC5_LUI: begin
               ty_s[T_RI] = 1'b1; code_s = OPC_LUI; wr_s = 1'b1; op2_sel_s = OP2_IMM_U; ok_s = 1'b1;
            end
            OPC5_AUIPC: begin
               ty_s[T_RI] = 1'b1; code_s = OPC_AUIPC; wr_s = 1'b1; ok_s = 1'b1;
               op1_sel_s = OP1_PC; op2_sel_s = OP2_IMM_U;
            end
            OPC5_SYSTEM: begin
               ty_s[T_SYS] = 1'b1; op2_sel_s = OP2_IMM_I;
               case (f3_s)
                  3'b000: begin
                     if (if_inst == 32'h0000_0073) begin
                        code_s = OPC_ECALL; ok_s = 1'b1;
                     end else if (if_inst == 32'h3020_0073) begin
                        code_s = OPC_MRET; ok_s = 1'b1;
                     end else begin
                        ok_s = 1'b0;
                     end
                  end
                  3'b001: begin code_s = OPC_CSRRW;  use1_s = 1'b1; wr_s = 1'b1; ok_s = 1'b1; end
                  3'b010: begin code_s = OPC_CSRRS;  use1_s = 1'b1; wr_s = 1'b1; ok_s = 1'b1; end
                  3'b011: begin code_s = OPC_CSRRC;  use1_s = 1'b1; wr_s = 1'b1; ok_s = 1'b1; end
                  3'b101: begin code_s = OPC_CSRRWI; op1_sel_s = OP1_UIMM; wr_s = 1'b1; ok_s = 1'b1; end
                  3'b110: begin code_s = OPC_CSRRSI; op1_sel_s = OP1_UIMM; wr_s = 1'b1; ok_s = 1'b1; end
                  3'b111: begin code_s = OPC_CSRRCI; op1_sel_s = OP1_UIMM; wr_s = 1'b1; ok_s = 1'b1; end
                  default: ok_s = 1'b0;
               endcase
            end
            default: ok_s = 1'b0;
         endcase
      end else begin
         ok_s = 1'b0;
      end
   end

   // Unknown encodings drop every side effect and travel down the pipe as a NOP
   assign rf_rs1_addr = (ok_s & use1_s) ? if_inst[19:15] : 5'd0;
   assign rf_rs2_addr = (ok_s & use2_s) ? if_inst[24:20] : 5'd0;

   logic [XLEN-1:0] rs1_val_s, rs2_val_s, imm_i_s, op1_s, op2_s, jalr_sum_s;
   logic [PC_W-1:0] jalr_raw_s;

   id_fwd_mux #(.NUM_FWD(NUM_FWD), .XLEN(XLEN)) u_fwd_rs1 (
      .rs_addr_i(rf_rs1_addr), .rf_data_i(rf_rs1_data), .fwd_ena_i(fwd_ena),
      .fwd_addr_i(fwd_addr), .fwd_data_i(fwd_data), .rs_data_o(rs1_val_s));
   id_fwd_mux #(.NUM_FWD(NUM_FWD), .XLEN(XLEN)) u_fwd_rs2 (
      .rs_addr_i(rf_rs2_addr), .rf_data_i(rf_rs2_data), .fwd_ena_i(fwd_ena),
      .fwd_addr_i(fwd_addr), .fwd_data_i(fwd_data), .rs_data_o(rs2_val_s));

   assign imm_i_s    = XLEN'(sext12(if_inst[31:20]));
   assign jalr_sum_s = rs1_val_s + imm_i_s;
   assign jalr_raw_s = PC_W'(jalr_sum_s);

   // Operand source selection
   always_comb begin
      op1_s = rs1_val_s;
      op2_s = rs2_val_s;
      case (op1_sel_s)
         OP1_PC:   op1_s = XLEN'(if_pc);
         OP1_UIMM: op1_s = XLEN'(if_inst[19:15]);
         default:  op1_s = rs1_val_s;
      endcase
      case (op2_sel_s)
         OP2_IMM_I: op2_s = imm_i_s;
         OP2_IMM_U: op2_s = XLEN'(sext32({if_inst[31:12], 12'h000}));
         OP2_PC:    op2_s = XLEN'(if_pc);
         default:   op2_s = rs2_val_s;
      endcase
   end

   logic ex_valid_q, ex_valid_d, ex_rd_w_ena_q, redirect_vld_q, redirect_vld_d;
   logic [7:0] ex_type_q, ex_opc_q;
   logic [XLEN-1:0] ex_op1_q, ex_op2_q;
   logic [4:0] ex_rd_q;
   logic [PC_W-1:0] ex_pc_q, redirect_pc_q, redirect_pc_d;
   logic [11:0] ex_moff_q;
   logic [2:0] ex_mop_q;
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic ld_in_out_s, hazard_s, accept_s;

   // A load parked in the output register is as dangerous as one already in EX
   assign ld_in_out_s = ex_valid_q & ex_type_q[T_LD] & ex_rd_w_ena_q;
   assign hazard_s =
      ((rf_rs1_addr != 5'd0) & ((exe_load_vld & (rf_rs1_addr == exe_load_rd)) |
                                (ld_in_out_s & (rf_rs1_addr == ex_rd_q)))) |
      ((rf_rs2_addr != 5'd0) & ((exe_load_vld & (rf_rs2_addr == exe_load_rd)) |
                                (ld_in_out_s & (rf_rs2_addr == ex_rd_q))));
   assign if_ready = ~hazard_s & ~flush_i & (~ex_valid_q | ex_ready);
   assign accept_s = if_valid & if_ready;

   // Next-state for handshake, redirect pulse and stall counter
   always_comb begin
      ex_valid_d = ex_valid_q; redirect_vld_d = 1'b0;
      redirect_pc_d = redirect_pc_q; stall_cnt_d = stall_cnt_q;
      if (flush_i) begin
         ex_valid_d = 1'b0;
      end else if (accept_s) begin
         ex_valid_d = 1'b1;
      end else if (ex_ready) begin
         ex_valid_d = 1'b0;
      end else begin
         ex_valid_d = ex_valid_q;
      end
      if (accept_s & ok_s & jalr_s) begin
         redirect_vld_d = 1'b1;
         redirect_pc_d  = {jalr_raw_s[PC_W-1:1], 1'b0};
      end else begin
         redirect_vld_d = 1'b0;
      end
      if (if_valid & hazard_s & ~flush_i & (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // State and output register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid_q <= 1'b0; redirect_vld_q <= 1'b0; redirect_pc_q <= '0; stall_cnt_q <= 16'd0;
         ex_type_q <= 8'h00; ex_opc_q <= 8'h00; ex_op1_q <= '0; ex_op2_q <= '0;
         ex_rd_w_ena_q <= 1'b0; ex_rd_q <= 5'd0; ex_pc_q <= '0; ex_moff_q <= 12'h000; ex_mop_q <= 3'd0;
      end else begin
         ex_valid_q <= ex_valid_d; redirect_vld_q <= redirect_vld_d;
         redirect_pc_q <= redirect_pc_d; stall_cnt_q <= stall_cnt_d;
         if (accept_s) begin
            ex_type_q     <= ok_s ? ty_s : 8'h00;
            ex_opc_q      <= ok_s ? code_s : OPC_NOP;
            ex_op1_q      <= op1_s;
            ex_op2_q      <= op2_s;
            ex_rd_w_ena_q <= ok_s & wr_s & (rd_s != 5'd0);
            ex_rd_q       <= (ok_s & wr_s) ? rd_s : 5'd0;
            ex_pc_q       <= if_pc;
            ex_moff_q     <= ok_s ? moff_s : 12'h000;
            ex_mop_q      <= ok_s ? f3_s : 3'd0;
         end
      end
   end

   assign ex_valid       = ex_valid_q;
   assign ex_inst_type   = ex_type_q;
   assign ex_inst_opcode = ex_opc_q;
   assign ex_op1         = ex_op1_q;
   assign ex_op2         = ex_op2_q;
   assign ex_rd_w_ena    = ex_rd_w_ena_q;
   assign ex_rd_w_addr   = ex_rd_q;
   assign ex_pc          = ex_pc_q;
   assign ex_mem_offset  = ex_moff_q;
   assign ex_mem_op      = ex_mop_q;
   assign redirect_vld   = redirect_vld_q;
   assign redirect_pc    = redirect_pc_q;
   assign stall_cnt      = stall_cnt_q;

endmodule
